// File: rtl/sram_port_arb.sv
// Three-way round-robin arbiter in front of a single-port SRAM.
// Two read ports (conv, FC) and one write port (writeback).
module sram_port_arb #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arb_en,
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          w_req,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_wdata,
  output logic          c_gnt,
  output logic          f_gnt,
  output logic          w_gnt,
  output logic          c_rvalid,
  output logic          f_rvalid,
  output logic [DW-1:0] rd_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  logic [1:0]  ptr_q, ptr_d;
  logic        c_rv_q, c_rv_d;
  logic        f_rv_q, f_rv_d;
  logic [15:0] cnt_q, cnt_d;

  logic [3:0]  req;
  logic [1:0]  s0, s1, s2;
  logic [1:0]  gidx;
  logic        any;
  logic        multi;

  // Requests are masked while disabled or in reset so no grant leaks out.
  always_comb begin
    req = {1'b0, w_req, f_req, c_req}
          & {4{arb_en & ~reset}};
    any = |req[2:0];
    multi = (req[0] & req[1])
          | (req[0] & req[2])
          | (req[1] & req[2]);
  end

  always_comb begin
    s0 = 2'd0;
    s1 = 2'd1;
    s2 = 2'd2;
    unique case (ptr_q)
      2'd0: begin
        s0 = 2'd1;
        s1 = 2'd2;
        s2 = 2'd0;
      end
      2'd1: begin
        s0 = 2'd2;
        s1 = 2'd0;
        s2 = 2'd1;
      end
      default: begin
        s0 = 2'd0;
        s1 = 2'd1;
        s2 = 2'd2;
      end
    endcase
  end

  // First active request in rotated order wins.
  always_comb begin
    gidx = ptr_q;
    priority case (1'b1)
      req[s0]: gidx = s0;
      req[s1]: gidx = s1;
      req[s2]: gidx = s2;
      default: gidx = ptr_q;
    endcase
  end

  always_comb begin
    c_gnt = any && (gidx == 2'd0);
    f_gnt = any && (gidx == 2'd1);
    w_gnt = any && (gidx == 2'd2);
  end

  always_comb begin
    mem_en    = any;
    mem_we    = w_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      c_gnt: mem_addr = c_addr;
      f_gnt: mem_addr = f_addr;
      w_gnt: begin
        mem_addr  = w_addr;
        mem_wdata = w_wdata;
      end
      default: mem_addr = '0;
    endcase
  end

  always_comb begin
    ptr_d  = any ? gidx : ptr_q;
    c_rv_d = c_gnt;
    f_rv_d = f_gnt;
    cnt_d  = cnt_q;
    if (multi && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  // ptr resets to 2 so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= 2'd2;
      c_rv_q <= 1'b0;
      f_rv_q <= 1'b0;
      cnt_q  <= 16'd0;
    end else begin
      ptr_q  <= ptr_d;
      c_rv_q <= c_rv_d;
      f_rv_q <= f_rv_d;
      cnt_q  <= cnt_d;
    end
  end

  assign c_rvalid     = c_rv_q;
  assign f_rvalid     = f_rv_q;
  assign rd_data      = mem_rdata;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_port_arb.sv
// Scoreboard bench for sram_port_arb with a small SRAM model.
// Stimulus pushes expected grants/returns; a negedge monitor pops them.
module tb_sram_port_arb;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          arb_en;
  logic          c_req, f_req, w_req;
  logic [AW-1:0] c_addr, f_addr, w_addr;
  logic [DW-1:0] w_wdata;
  logic          c_gnt, f_gnt, w_gnt;
  logic          c_rvalid, f_rvalid;
  logic [DW-1:0] rd_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   conflict_cnt;

  int nvec = 0;
  int nmis = 0;
  bit bulk = 1'b0;

  typedef struct {
    logic [2:0]    g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } gexp_t;

  typedef struct {
    logic [1:0]    r;
    logic [DW-1:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  sram_port_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en),
    .c_req(c_req), .c_addr(c_addr),
    .f_req(f_req), .f_addr(f_addr),
    .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata),
    .c_gnt(c_gnt), .f_gnt(f_gnt), .w_gnt(w_gnt),
    .c_rvalid(c_rvalid), .f_rvalid(f_rvalid),
    .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten words read back as {4'h5, addr}.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit   [(1<<AW)-1:0] wvld;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]  <= mem_wdata;
        wvld[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wvld[mem_addr] ? mem[mem_addr]
                                    : {4'h5, mem_addr};
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_g(logic [2:0] g, logic [AW-1:0] a,
                        logic [DW-1:0] d);
    gexp_t e;
    e.g = g;
    e.we = g[2];
    e.a = a;
    e.d = d;
    gq.push_back(e);
  endtask

  task automatic push_r(logic [1:0] r, logic [DW-1:0] d);
    rexp_t e;
    e.r = r;
    e.d = d;
    rq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic [2:0] gv;
  logic [1:0] rv;
  gexp_t      ge;
  rexp_t      re;
  always @(negedge clk) begin
    if (!reset && !bulk) begin
      gv = {w_gnt, f_gnt, c_gnt};
      rv = {f_rvalid, c_rvalid};
      if (gv != 3'b0 || mem_en) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant",
              {gv, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        end else begin
          ge = gq.pop_front();
          chk("grant",
              {gv, mem_en, mem_we, mem_addr, mem_wdata},
              {ge.g, 1'b1, ge.we, ge.a, ge.d});
        end
      end
      if (rv != 2'b0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", {rv, rd_data}, 64'd0);
        end else begin
          re = rq.pop_front();
          chk("rvalid", {rv, rd_data}, {re.r, re.d});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    arb_en = 1'b1;
    c_req = 1'b1; f_req = 1'b1; w_req = 1'b1;
    c_addr = 12'h010; f_addr = 12'h020; w_addr = 12'h030;
    w_wdata = 16'h1234;
    repeat (2) cyc();
    chk("reset_outputs",
        {c_gnt, f_gnt, w_gnt, c_rvalid, f_rvalid, mem_en, mem_we,
         mem_addr, mem_wdata, conflict_cnt}, 64'd0);
    c_req = 1'b0; f_req = 1'b0; w_req = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("cnt_after_reset", conflict_cnt, 64'd0);

    // All three contend: c,f,w,c,f,w
    c_req = 1'b1; f_req = 1'b1; w_req = 1'b1;
    push_g(3'b001, 12'h010, 16'h0);
    push_g(3'b010, 12'h020, 16'h0);
    push_g(3'b100, 12'h030, 16'h1234);
    push_g(3'b001, 12'h010, 16'h0);
    push_g(3'b010, 12'h020, 16'h0);
    push_g(3'b100, 12'h030, 16'h1234);
    push_r(2'b01, 16'h5010);
    push_r(2'b10, 16'h5020);
    push_r(2'b01, 16'h5010);
    push_r(2'b10, 16'h5020);
    repeat (6) cyc();
    c_req = 1'b0; f_req = 1'b0; w_req = 1'b0;
    chk("cnt_after_rr", conflict_cnt, 64'd6);
    cyc();

    // Lone write to top of used range
    w_req = 1'b1; w_addr = 12'h7FF; w_wdata = 16'hBEEF;
    push_g(3'b100, 12'h7FF, 16'hBEEF);
    cyc();
    w_req = 1'b0;
    repeat (2) cyc();

    // Lone f reads, 4 back-to-back
    f_req = 1'b1; f_addr = 12'h040;
    repeat (4) begin
      push_g(3'b010, 12'h040, 16'h0);
      push_r(2'b10, 16'h5040);
    end
    repeat (4) cyc();
    f_req = 1'b0;
    cyc();
    chk("cnt_no_contention", conflict_cnt, 64'd6);

    // Read back the written word
    c_req = 1'b1; c_addr = 12'h7FF;
    push_g(3'b001, 12'h7FF, 16'h0);
    push_r(2'b01, 16'hBEEF);
    cyc();
    c_req = 1'b0;
    cyc();

    // Write so that ptr lands on 2
    w_req = 1'b1; w_addr = 12'h050; w_wdata = 16'h0BAD;
    push_g(3'b100, 12'h050, 16'h0BAD);
    cyc();
    w_req = 1'b0;
    cyc();

    // Disabled arbitration
    arb_en = 1'b0;
    c_req = 1'b1; c_addr = 12'h060;
    f_req = 1'b1; f_addr = 12'h070;
    for (int i = 0; i < 5; i++) begin
      chk("disabled_no_grant",
          {c_gnt, f_gnt, w_gnt, mem_en}, 64'd0);
      cyc();
    end
    chk("cnt_while_disabled", conflict_cnt, 64'd6);
    arb_en = 1'b1;
    push_g(3'b001, 12'h060, 16'h0);
    push_g(3'b010, 12'h070, 16'h0);
    push_r(2'b01, 16'h5060);
    push_r(2'b10, 16'h5070);
    cyc();
    c_req = 1'b0;
    cyc();
    // f return must still come out with arbitration off
    f_req = 1'b0;
    arb_en = 1'b0;
    chk("cnt_after_enable", conflict_cnt, 64'd7);
    cyc();
    arb_en = 1'b1;
    cyc();

    // Reset right after a c grant drops the pending return
    c_req = 1'b1; c_addr = 12'h0A0;
    push_g(3'b001, 12'h0A0, 16'h0);
    cyc();
    reset = 1'b1;
    c_req = 1'b0;
    #1;
    chk("reset_kills_rvalid",
        {c_rvalid, f_rvalid, conflict_cnt}, 64'd0);
    cyc();
    chk("reset_held",
        {c_gnt, c_rvalid, mem_en, conflict_cnt}, 64'd0);
    reset = 1'b0;
    cyc();
    chk("no_reissue", {c_rvalid, f_rvalid}, 64'd0);
    c_req = 1'b1; f_req = 1'b1; w_req = 1'b1;
    c_addr = 12'h0B0; f_addr = 12'h0C0; w_addr = 12'h0D0;
    push_g(3'b001, 12'h0B0, 16'h0);
    push_r(2'b01, 16'h50B0);
    cyc();
    c_req = 1'b0; f_req = 1'b0; w_req = 1'b0;
    chk("cnt_after_reset2", conflict_cnt, 64'd1);
    repeat (2) cyc();

    // Saturation
    bulk = 1'b1;
    c_req = 1'b1; f_req = 1'b1;
    repeat (65533) cyc();
    chk("cnt_fffe", conflict_cnt, 64'hFFFE);
    repeat (2) cyc();
    chk("cnt_sat", conflict_cnt, 64'hFFFF);
    repeat (3) cyc();
    chk("cnt_sat_hold", conflict_cnt, 64'hFFFF);
    c_req = 1'b0; f_req = 1'b0;
    repeat (2) cyc();
    bulk = 1'b0;
    cyc();

    chk("grant_queue_drained", gq.size(), 64'd0);
    chk("rvalid_queue_drained", rq.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 The block SHALL have parameter AW, default 12, the SRAM address width.
REQ-002 The block SHALL have parameter DW, default 16, the SRAM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port arb_en, input, 1; when low, no grants are issued.
REQ-006 The block SHALL have ports c_req / c_addr, input, 1 / AW, the conv-engine read request and address (requester 0).
REQ-007 The block SHALL have ports f_req / f_addr, input, 1 / AW, the FC-engine read request and address (requester 1).
REQ-008 The block SHALL have ports w_req / w_addr / w_wdata, input, 1 / AW / DW, the result-writeback write request (requester 2).
REQ-009 The block SHALL have ports c_gnt, f_gnt, w_gnt, output, 1 each, the per-requester grant.
REQ-010 The block SHALL have ports c_rvalid, f_rvalid, output, 1 each, the read-data valid strobe for the returning read.
REQ-011 The block SHALL have port rd_data, output, DW, the read data shared by both readers; it is mem_rdata passed through.
REQ-012 The block SHALL have ports mem_en / mem_we / mem_addr / mem_wdata, output, 1 / 1 / AW / DW, the single-port SRAM command.
REQ-013 The block SHALL have port mem_rdata, input, DW, the SRAM read data, valid one cycle after a read command.
REQ-014 The block SHALL have port conflict_cnt, output, 16, the saturating count of contention cycles.

Function
REQ-015 Handshake: a transfer occurs in a cycle where x_req and x_gnt are both high; the requester holds x_req, address and data stable until that cycle.
REQ-016 At most one of c_gnt, f_gnt, w_gnt SHALL be high in any cycle; grants are combinational from the requests, arb_en and ptr.
REQ-017 Arbitration: round-robin over indices 0,1,2; search starts at (ptr+1) mod 3 and grants the first active request.
REQ-018 ptr (2 bits) SHALL load the granted index on every transfer and hold otherwise; value 3 is unreachable.
REQ-019 No request, or arb_en low -> all grants 0, mem_en 0, ptr holds.
REQ-020 During a transfer, mem_en=1 and mem_addr is the granted address. mem_we=1 and mem_wdata=w_wdata only for requester 2. Otherwise mem_we=0 and mem_wdata=0.
REQ-021 Read return: c_rvalid / f_rvalid SHALL be registered and pulse for exactly one cycle, the cycle after the corresponding read grant.
REQ-022 Back-to-back reads SHALL be supported at one per cycle with no bubble; write grants produce no rvalid.
REQ-023 Contention: each cycle with two or more requests high and arb_en=1 SHALL increment conflict_cnt, which saturates at 16'hFFFF.
REQ-024 Fairness: a continuously asserted request SHALL be granted within 3 cycles while arb_en=1.
REQ-025 A requester dropping x_req without a grant is permitted; no state changes result.
REQ-026 An rvalid pending from the last enabled cycle SHALL still be issued after arb_en falls.

Reset
REQ-027 On reset: ptr=2, so requester 0 has first priority. All gnt, rvalid and mem_* outputs are 0, and conflict_cnt=0.
REQ-028 Reset asserted mid-operation SHALL clear immediately and asynchronously; any pending rvalid is discarded and not reissued.
REQ-029 Outputs SHALL stay at reset values while reset is high, regardless of requests.

Verification
REQ-030 After reset, assert c_req, f_req and w_req continuously (addrs 0x010/0x020/0x030) -> grants cycle c,f,w,c,f,w. conflict_cnt=6 after 6 cycles. c_rvalid pulses the cycle after each c grant, with rd_data = mem_rdata.
REQ-031 Apply a single w_req, addr 0x7FF, wdata 0xBEEF -> same cycle: w_gnt=1, mem_en=1, mem_we=1, mem_addr=0x7FF, mem_wdata=0xBEEF. No rvalid follows.
REQ-032 Hold f_req for 4 consecutive cycles alone -> f_gnt 4 cycles and f_rvalid 4 consecutive cycles, lagging by one. conflict_cnt stays 0.
REQ-033 Apply c_req and f_req with arb_en=0 for 5 cycles, then raise arb_en -> no grants or mem_en during the 5 cycles and conflict_cnt unchanged. After arb_en rises, c is granted first, then f.
REQ-034 Assert reset in the cycle after a c grant -> c_rvalid never pulses, ptr returns to 2, conflict_cnt=0, and the next c_req is granted first.
REQ-035 Preload conflict_cnt to 0xFFFE via 2 extra contention cycles -> the count stops at 0xFFFF and holds under further contention.
